core_wb_scoreboard: RTL
=======================

// Module: core_wb_scoreboard
// PURPOSE
//  Sequences the single regfile write port and tracks outstanding long-latency writes.
//  - Three writeback sources share the port:
//    - ALU: single-cycle, no backpressure.
//    - LSU: load data, valid/ready handshake.
//    - MDU: mul/div result, valid/ready handshake.
//  - A per-register scoreboard gives decode a RAW/WAW stall.
//  - Position: between EX/MEM/MDU and core_regfile, with the hazard output going to ID.
// PARAMETERS
//  XLEN     32   register data width
//  REG_NUM  32   number of architectural registers (x0 is hard-wired to zero)
//  REG_AW   5    register address width, equal to clog2(REG_NUM)
// PORTS
//  clk           in   1       core clock
//  rst_n         in   1       asynchronous active-low reset
//  alu_wb_valid  in   1       ALU result valid this cycle
//  alu_wb_rd     in   REG_AW  ALU destination register
//  alu_wb_data   in   XLEN    ALU result
//  lsu_wb_valid  in   1       load result valid
//  lsu_wb_ready  out  1       load result accepted
//  lsu_wb_rd     in   REG_AW  load destination register
//  lsu_wb_data   in   XLEN    load data
//  mdu_wb_valid  in   1       MDU result valid
//  mdu_wb_ready  out  1       MDU result accepted
//  mdu_wb_rd     in   REG_AW  MDU destination register
//  mdu_wb_data   in   XLEN    MDU result
//  iss_valid     in   1       long-latency op (load/mul/div) issued this cycle
//  iss_rd        in   REG_AW  its destination register
//  dec_rs1/rs2/rd     in  REG_AW  decode-stage register addresses
//  dec_rs1_en/rs2_en/rd_en in 1   corresponding use enables
//  hz_stall      out  1       decode must stall (combinational)
//  sb_busy       out  1       at least one pending bit set (for fence/flush)
//  rf_wen        out  1       regfile write enable (registered)
//  rf_waddr      out  REG_AW  regfile write address (registered)
//  rf_wdata      out  XLEN    regfile write data (registered)
// BEHAVIOUR
//  Reset values:
//  - rf_wen=0, rf_waddr=0, rf_wdata=0.
//  - Every pending bit is 0, so sb_busy=0.
//  - Round-robin pointer selects LSU first.
//  - Reset asserted mid-operation drops all in-flight grants and clears every pending bit.
//  Arbitration (combinational in cycle N, write registered at N+1, so latency is 1):
//  - ALU with alu_wb_valid=1 and rd!=0 always wins the port.
//  - When the ALU does not take the port, LSU and MDU alternate round-robin.
//    - The pointer flips only on an actual LSU/MDU grant.
//  - The loser sees ready=0 and must hold valid, rd and data stable.
//  - rd==0 from any source:
//    - The result is accepted immediately (ready=1, irrespective of the ALU).
//    - rf_wen stays 0 and the port is not occupied.
//  - At most one rf_wen per cycle; rf_wen=0 in every cycle with no grant.
//  Scoreboard (REG_NUM-1 bits; x0 has no bit):
//  - Set: iss_valid with iss_rd!=0 sets pend[iss_rd] at the clock edge.
//  - Clear: pend[a] clears at the edge ending the cycle in which rf_wen=1 and rf_waddr=a.
//    - Consequence: decode stalls through the write cycle and reads the new value in the following cycle.
//  - Set and clear of the same register on the same edge: the set wins.
//  - hz_stall=1 when any enabled dec_rs1/dec_rs2/dec_rd (nonzero) has its pending bit set.
//    - Checking dec_rd covers WAW.
//  - hz_stall=1 also when an LSU/MDU grant is registered for that address, i.e. the pending bit is still set.
//  - sb_busy = OR of all pending bits.
//  Protocol violations (flagged by assertions, no defined RTL response):
//  - iss_valid while hz_stall=1.
//  - iss_rd already pending.
//  - ALU writing a pending rd.
// TESTING
//  1. ALU only: alu_wb_valid=1, rd=5, data=0x1234 at cycle N -> rf_wen=1, waddr=5, wdata=0x1234 at N+1.
//  2. Contention: ALU rd=3, LSU rd=7 and MDU rd=9 valid together ->
//     - ALU written first.
//     - LSU next (pointer at reset).
//     - MDU last.
//     - lsu_wb_ready/mdu_wb_ready are low while losing.
//  3. Round robin: LSU and MDU both valid continuously with the ALU idle -> grants alternate L,M,L,M.
//  4. Scoreboard: iss_valid rd=10, then dec_rs1=10 with rs1_en=1 ->
//     - hz_stall=1 until the cycle after rf_wen for x10.
//     - hz_stall=0 once the LSU result writes x10.
//  5. x0: LSU valid with rd=0 -> lsu_wb_ready=1, no rf_wen; iss_valid rd=0 -> sb_busy stays 0.
//  6. Reset during pending: set pend[4], assert rst_n=0 mid-cycle -> sb_busy=0, rf_wen=0, hz_stall=0 immediately.

Source files
------------

// File: rtl/core_wb_scoreboard.sv
// Writeback port sequencer (ALU > round-robin LSU/MDU) plus a per-register
// pending scoreboard that raises a RAW/WAW stall toward decode.
module core_wb_scoreboard #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_wb_valid,
  input  logic [REG_AW-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]   alu_wb_data,
  input  logic              lsu_wb_valid,
  output logic              lsu_wb_ready,
  input  logic [REG_AW-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]   lsu_wb_data,
  input  logic              mdu_wb_valid,
  output logic              mdu_wb_ready,
  input  logic [REG_AW-1:0] mdu_wb_rd,
  input  logic [XLEN-1:0]   mdu_wb_data,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_rs1_en,
  input  logic              dec_rs2_en,
  input  logic              dec_rd_en,
  output logic              hz_stall,
  output logic              sb_busy,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata
);

  // Handshake: a result transfers in any cycle where valid && ready are both
  // high; a source seeing ready=0 holds valid, rd and data unchanged.

  logic                 r_rr_lsu;  // 1: LSU has priority on the next LSU/MDU contention
  logic [REG_NUM-1:1]   r_pend;

  logic                 w_alu_take;
  logic                 w_lsu_req;
  logic                 w_mdu_req;
  logic                 w_lsu_gnt;
  logic                 w_mdu_gnt;
  logic                 w_wen;
  logic [REG_AW-1:0]    w_waddr;
  logic [XLEN-1:0]      w_wdata;
  logic [REG_NUM-1:0]   w_pend_full;
  logic [REG_NUM-1:1]   w_set;
  logic [REG_NUM-1:1]   w_clr;
  logic                 w_hz_rs1;
  logic                 w_hz_rs2;
  logic                 w_hz_rd;

  assign w_alu_take = alu_wb_valid && (alu_wb_rd != '0);
  assign w_lsu_req  = lsu_wb_valid && (lsu_wb_rd != '0);
  assign w_mdu_req  = mdu_wb_valid && (mdu_wb_rd != '0);

  assign w_lsu_gnt  = !w_alu_take && w_lsu_req && (!w_mdu_req || r_rr_lsu);
  assign w_mdu_gnt  = !w_alu_take && w_mdu_req && (!w_lsu_req || !r_rr_lsu);

  // x0 results are swallowed without touching the port.
  assign lsu_wb_ready = (lsu_wb_valid && (lsu_wb_rd == '0)) || w_lsu_gnt;
  assign mdu_wb_ready = (mdu_wb_valid && (mdu_wb_rd == '0)) || w_mdu_gnt;

  always_comb begin
    w_wen   = w_alu_take || w_lsu_gnt || w_mdu_gnt;
    w_waddr = alu_wb_rd;
    w_wdata = alu_wb_data;
    if (!w_alu_take) begin
      if (w_lsu_gnt) begin
        w_waddr = lsu_wb_rd;
        w_wdata = lsu_wb_data;
      end else if (w_mdu_gnt) begin
        w_waddr = mdu_wb_rd;
        w_wdata = mdu_wb_data;
      end
    end
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 1; i < REG_NUM; i++) begin
      w_set[i] = iss_valid && (iss_rd == REG_AW'(i));
      w_clr[i] = rf_wen && (rf_waddr == REG_AW'(i));
    end
  end

  assign w_pend_full = {r_pend, 1'b0};
  assign w_hz_rs1    = dec_rs1_en && (dec_rs1 != '0) && w_pend_full[dec_rs1];
  assign w_hz_rs2    = dec_rs2_en && (dec_rs2 != '0) && w_pend_full[dec_rs2];
  assign w_hz_rd     = dec_rd_en  && (dec_rd  != '0) && w_pend_full[dec_rd];
  assign hz_stall    = w_hz_rs1 || w_hz_rs2 || w_hz_rd;
  assign sb_busy     = |r_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_lsu <= 1'b1;
      r_pend   <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (w_lsu_gnt)      r_rr_lsu <= 1'b0;
      else if (w_mdu_gnt) r_rr_lsu <= 1'b1;
      // Set after clear so a same-edge issue to the register being written wins.
      r_pend <= (r_pend & ~w_clr) | w_set;
      rf_wen <= w_wen;
      if (w_wen) begin
        rf_waddr <= w_waddr;
        rf_wdata <= w_wdata;
      end
    end
  end

  a_iss_during_stall: assert property (@(posedge clk) disable iff (!rst_n)
    !(iss_valid && hz_stall));
  a_iss_rd_pending: assert property (@(posedge clk) disable iff (!rst_n)
    !(iss_valid && w_pend_full[iss_rd]));
  a_alu_rd_pending: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_alu_take && w_pend_full[alu_wb_rd]));

endmodule
